cart_load_ctrl: RTL and testbench

Sequences HPS cartridge downloads into the cart dual-port RAM and parses the A78 header. It computes the payload size and holds the console core in reset until the image is complete. It sits between hps_io's ioctl interface and the cart RAM write port (port B), and replaces the ad-hoc header and reset logic in the top-level emu.
- Single writer for RAM port B.
- Single source of core reset for cart loads.

---
 rtl/cart_load_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_cart_load_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_load_ctrl.sv
// Cart download sequencer: writes HPS images into cart RAM port B, parses the A78 header,
// and holds the core in reset until loading is done. Define CART_PAD_EN to enable 0xFF padding.
module cart_load_ctrl #(
  parameter int unsigned ADDR_W   = 18,
  parameter int unsigned HDR_LEN  = 128,
  parameter int unsigned HOLD_CYC = 16
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              ioctl_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_we,
  output logic              cart_is_7800,
  output logic [31:0]       cart_size,
  output logic [15:0]       cart_flags,
  output logic              cart_region,
  output logic              core_reset,
  output logic              busy
);

  localparam int unsigned CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [24:0] HDR_A = 25'(HDR_LEN);
  localparam logic [31:0] HDR_S = 32'(HDR_LEN);
  localparam logic [39:0] MAGIC = 40'h41_54_41_52_49;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
`ifdef CART_PAD_EN
    S_PAD,
`endif
    S_HOLD,
    S_RUN
  } state_t;

  state_t             state_q, state_d;
  logic               cart_dl, cart_dl_q, dl_rise, dl_fall;
  logic [39:0]        magic_q, magic_d;
  logic [15:0]        flags_q, flags_d;
  logic               region_q, region_d;
  logic [24:0]        last_addr_q, last_addr_d;
  logic               any_wr_q, any_wr_d;
  logic [31:0]        size_q, size_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
  logic [7:0]         ram_data_q, ram_data_d;
  logic               ram_we_q, ram_we_d;
  logic               is_7800;
  logic [24:0]        xl_addr;
  logic               in_range;
  logic [31:0]        total, size_calc;
`ifdef CART_PAD_EN
  logic [ADDR_W:0]    pad_addr_q, pad_addr_d, pad_end_q, pad_end_d;
  logic [32:0]        pad_top, pad_cap;
`endif

  always_comb begin
    cart_dl  = ioctl_download & (ioctl_index != 8'd0);
    dl_rise  = cart_dl & ~cart_dl_q;
    dl_fall  = ~cart_dl & cart_dl_q;
    is_7800  = (magic_q == MAGIC);
    xl_addr  = (is_7800 && ioctl_addr >= HDR_A) ? ioctl_addr - HDR_A : ioctl_addr;
    in_range = ((xl_addr >> ADDR_W) == '0);
    total    = 32'(last_addr_q) + 32'd1;
    if (!any_wr_q)
      size_calc = '0;
    else if (!is_7800)
      size_calc = total;
    else if (total <= HDR_S)
      size_calc = '0;
    else
      size_calc = total - HDR_S;
  end

`ifdef CART_PAD_EN
  always_comb begin
    pad_cap = 33'd1 << ADDR_W;
    pad_top = 33'd4096;
    for (int unsigned i = 0; i < ADDR_W; i++) begin
      if (pad_top < {1'b0, size_calc} && pad_top < pad_cap)
        pad_top = pad_top << 1;
    end
    if (pad_top > pad_cap)
      pad_top = pad_cap;
  end
`endif

  always_comb begin
    state_d     = state_q;
    magic_d     = magic_q;
    flags_d     = flags_q;
    region_d    = region_q;
    last_addr_d = last_addr_q;
    any_wr_d    = any_wr_q;
    size_d      = size_q;
    cnt_d       = cnt_q;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;
    ram_we_d    = 1'b0;
`ifdef CART_PAD_EN
    pad_addr_d  = pad_addr_q;
    pad_end_d   = pad_end_q;
`endif
    if (dl_rise) begin
      state_d     = S_LOAD;
      magic_d     = '0;
      flags_d     = '0;
      region_d    = 1'b0;
      last_addr_d = '0;
      any_wr_d    = 1'b0;
      cnt_d       = CNT_W'(HOLD_CYC - 1);
    end else begin
      case (state_q)
        S_LOAD: begin
          if (dl_fall) begin
            size_d  = size_calc;
            state_d = S_HOLD;
            cnt_d   = CNT_W'(HOLD_CYC - 1);
`ifdef CART_PAD_EN
            if ({1'b0, size_calc} < pad_top) begin
              state_d    = S_PAD;
              pad_addr_d = size_calc[ADDR_W:0];
              pad_end_d  = pad_top[ADDR_W:0];
            end
`endif
          end else if (ioctl_wr) begin
            last_addr_d = ioctl_addr;
            any_wr_d    = 1'b1;
            if (ioctl_addr >= 25'd1 && ioctl_addr <= 25'd5)
              magic_d = {magic_q[31:0], ioctl_dout};
            if (ioctl_addr == 25'd53)
              flags_d[15:8] = ioctl_dout;
            if (ioctl_addr == 25'd54)
              flags_d[7:0] = ioctl_dout;
            if (ioctl_addr == 25'd57)
              region_d = ioctl_dout[0];
            if (in_range) begin
              ram_we_d   = 1'b1;
              ram_addr_d = xl_addr[ADDR_W-1:0];
              ram_data_d = ioctl_dout;
            end
          end
        end
`ifdef CART_PAD_EN
        S_PAD: begin
          ram_we_d   = 1'b1;
          ram_addr_d = pad_addr_q[ADDR_W-1:0];
          ram_data_d = 8'hFF;
          pad_addr_d = pad_addr_q + 1'b1;
          if (pad_addr_q + 1'b1 == pad_end_q) begin
            state_d = S_HOLD;
            cnt_d   = CNT_W'(HOLD_CYC - 1);
          end
        end
`endif
        S_HOLD: begin
          if (cnt_q == '0)
            state_d = S_RUN;
          else
            cnt_d = cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // cart_dl_q resets high so a download still active across reset is not seen as a new rise.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cart_dl_q   <= 1'b1;
      magic_q     <= '0;
      flags_q     <= '0;
      region_q    <= 1'b0;
      last_addr_q <= '0;
      any_wr_q    <= 1'b0;
      size_q      <= '0;
      cnt_q       <= '0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      ram_we_q    <= 1'b0;
`ifdef CART_PAD_EN
      pad_addr_q  <= '0;
      pad_end_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cart_dl_q   <= cart_dl;
      magic_q     <= magic_d;
      flags_q     <= flags_d;
      region_q    <= region_d;
      last_addr_q <= last_addr_d;
      any_wr_q    <= any_wr_d;
      size_q      <= size_d;
      cnt_q       <= cnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      ram_we_q    <= ram_we_d;
`ifdef CART_PAD_EN
      pad_addr_q  <= pad_addr_d;
      pad_end_q   <= pad_end_d;
`endif
    end
  end

  assign ram_addr     = ram_addr_q;
  assign ram_data     = ram_data_q;
  assign ram_we       = ram_we_q;
  assign cart_is_7800 = is_7800;
  assign cart_size    = size_q;
  assign cart_flags   = flags_q;
  assign cart_region  = region_q;
  assign core_reset   = (state_q != S_RUN);
  assign busy         = (state_q != S_RUN);

endmodule

// File: tb/tb_cart_load_ctrl.sv
// Scoreboard bench for cart_load_ctrl: expected RAM writes are queued by the stimulus and
// popped by a negedge monitor; header, size and reset timing are checked directly.
module tb_cart_load_ctrl;
  localparam int unsigned AW = 18;
  localparam int unsigned HC = 16;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          ioctl_download = 1'b0;
  logic [7:0]    ioctl_index = '0;
  logic [24:0]   ioctl_addr = '0;
  logic [7:0]    ioctl_dout = '0;
  logic          ioctl_wr = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_data;
  logic          ram_we;
  logic          cart_is_7800;
  logic [31:0]   cart_size;
  logic [15:0]   cart_flags;
  logic          cart_region;
  logic          core_reset;
  logic          busy;

  int checks = 0;
  int errors = 0;
  logic [25:0] exp_q[$];
  bit rst_low_seen = 0;
  bit rst_high_seen = 0;

  always #5 clk_sys = ~clk_sys;

  cart_load_ctrl #(.ADDR_W(AW), .HDR_LEN(128), .HOLD_CYC(HC)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .cart_is_7800(cart_is_7800), .cart_size(cart_size), .cart_flags(cart_flags),
    .cart_region(cart_region), .core_reset(core_reset), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [7:0] img_byte(input int kind, input int unsigned a);
    logic [39:0] m;
    logic [31:0] av;
    m  = 40'h4154415249;
    av = a;
    if (kind == 1) begin
      if (a >= 1 && a <= 5) return m[8*(5-a) +: 8];
      if (a == 54) return 8'h02;
      if (a == 57) return 8'h01;
      if (a < 128) return 8'h00;
      return av[7:0] ^ 8'hA5;
    end
    return av[7:0] ^ 8'h5A;
  endfunction

  function automatic int unsigned pad_top(input int unsigned size);
    int unsigned p;
    p = 4096;
    while (p < size && p < (1 << AW)) p = p * 2;
    return p;
  endfunction

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, input bit is78, input bit expect_w);
    logic [24:0] ta;
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    if (expect_w) begin
      ta = (is78 && a >= 25'd128) ? a - 25'd128 : a;
      if (ta < 25'(1 << AW)) exp_q.push_back({ta[AW-1:0], d});
    end
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic send_image(input int kind, input int unsigned n, input bit expect_w);
    for (int unsigned a = 0; a < n; a++)
      wr_byte(25'(a), img_byte(kind, a), (kind == 1 && a >= 6), expect_w);
  endtask

  task automatic finish_dl(input string name, input int unsigned exp_size);
    int unsigned npad;
    int unsigned n;
    npad = 0;
`ifdef CART_PAD_EN
    if (exp_size < pad_top(exp_size)) begin
      npad = pad_top(exp_size) - exp_size;
      for (int unsigned x = exp_size; x < pad_top(exp_size); x++)
        exp_q.push_back({AW'(x), 8'hFF});
    end
`endif
    ioctl_download = 1'b0;
    tick();
    chk({name, "_busy_at_exit"}, 32'(busy), 32'd1);
    n = 0;
    while (core_reset === 1'b1 && n < 20000) begin
      tick();
      n++;
    end
    chk({name, "_reset_release_cycles"}, n, HC + npad);
    chk({name, "_cart_size"}, cart_size, exp_size);
    chk({name, "_busy_in_run"}, 32'(busy), 32'd0);
  endtask

  initial begin : monitor
    logic [25:0] e;
    forever begin
      @(negedge clk_sys);
      if (core_reset) rst_high_seen = 1; else rst_low_seen = 1;
      if (reset_n && ram_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ram_we", 32'(ram_we), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("ram_write", {6'd0, ram_addr, ram_data}, {6'd0, e});
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : stim
    repeat (3) tick();
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_data", 32'(ram_data), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_is_7800", 32'(cart_is_7800), 32'd0);
    chk("rst_cart_size", cart_size, 32'd0);
    chk("rst_cart_flags", 32'(cart_flags), 32'd0);
    chk("rst_cart_region", 32'(cart_region), 32'd0);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_busy", 32'(busy), 32'd1);
    reset_n = 1'b1;
    repeat (2) tick();
    chk("idle_core_reset", 32'(core_reset), 32'd1);

    // 7800 image: header + 16384 payload bytes
    start_dl(8'd1);
    chk("t1_core_reset_on_rise", 32'(core_reset), 32'd1);
    send_image(1, 128 + 16384, 1);
    finish_dl("t1", 16384);
    chk("t1_is_7800", 32'(cart_is_7800), 32'd1);
    chk("t1_flags", 32'(cart_flags), 32'h0002);
    chk("t1_region", 32'(cart_region), 32'd1);

    // 2600 image of 4096 bytes
    start_dl(8'd2);
    send_image(0, 4096, 1);
    finish_dl("t2", 4096);
    chk("t2_is_7800", 32'(cart_is_7800), 32'd0);

    // BIOS download while running
    start_dl(8'd0);
    rst_high_seen = 0;
    send_image(0, 10, 0);
    ioctl_download = 1'b0;
    repeat (5) tick();
    chk("t3_core_reset_stayed_low", 32'(rst_high_seen), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_cart_size_kept", cart_size, 32'd4096);

    // New download three cycles into HOLD
    start_dl(8'd1);
    rst_low_seen = 0;
    send_image(0, 4096, 1);
    ioctl_download = 1'b0;
    repeat (3) tick();
    start_dl(8'd1);
    send_image(1, 136, 1);
    chk("t5_core_reset_held", 32'(rst_low_seen), 32'd0);
    chk("t5_old_size_before_exit", cart_size, 32'd4096);
    finish_dl("t5", 8);
    chk("t5_is_7800", 32'(cart_is_7800), 32'd1);

    // reset_n pulse at byte 200 of a 7800 load
    start_dl(8'd1);
    for (int unsigned a = 0; a < 200; a++)
      wr_byte(25'(a), img_byte(1, a), (a >= 6), 1);
    @(negedge clk_sys);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t4_core_reset", 32'(core_reset), 32'd1);
    chk("t4_cart_size", cart_size, 32'd0);
    chk("t4_is_7800", 32'(cart_is_7800), 32'd0);
    chk("t4_ram_we", 32'(ram_we), 32'd0);
    chk("t4_flags", 32'(cart_flags), 32'd0);
    chk("t4_busy", 32'(busy), 32'd1);
    repeat (2) tick();
    reset_n = 1'b1;
    for (int unsigned a = 200; a < 300; a++)
      wr_byte(25'(a), img_byte(1, a), 1'b0, 1'b0);
    ioctl_download = 1'b0;
    repeat (4) tick();
    chk("t4_still_idle_reset", 32'(core_reset), 32'd1);
    chk("t4_size_after", cart_size, 32'd0);

    // Download with zero writes
    start_dl(8'd3);
    tick();
    finish_dl("zero", 0);
    chk("zero_is_7800", 32'(cart_is_7800), 32'd0);

    // 7800 image that is only a header
    start_dl(8'd1);
    send_image(1, 128, 1);
    finish_dl("hdr_only", 0);
    chk("hdr_only_is_7800", 32'(cart_is_7800), 32'd1);
    chk("hdr_only_flags", 32'(cart_flags), 32'h0002);

    // Top of RAM kept, first address past it dropped
    start_dl(8'd2);
    wr_byte(25'd0, 8'h11, 1'b0, 1'b1);
    wr_byte(25'd262143, 8'h22, 1'b0, 1'b1);
    wr_byte(25'd262144, 8'h33, 1'b0, 1'b1);
    finish_dl("bound", 262145);
    chk("bound_is_7800_cleared", 32'(cart_is_7800), 32'd0);

    // 6000-byte 2600 image (padded to 8192 when padding is built in)
    start_dl(8'd1);
    send_image(0, 6000, 1);
    finish_dl("t6", 6000);

    repeat (3) tick();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
